// File: rtl/arashi_cache_stream.sv
`default_nettype none
// ============================================================================
// Module      : arashi_cache_stream
// Description : Collects one line of words from a valid/ready source, then
//               streams the words one per cycle to the thread read buffer.
//               Words are issued only while a credit is held, because the
//               read buffer drops writes when it is full.
// Revision    : 1.0 - initial release
// ============================================================================
module arashi_cache_stream #(
  parameter int DATA_WIDTH       = 32,
  parameter int MEM_WIDTH        = 4,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int LINE_WIDTH       = 3
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_last,
  output logic                              cache_ready,
  output logic [DATA_WIDTH-1:0]             cache2mem,
  input  logic [(1<<THREAD_NUM_WIDTH)-1:0]  r_ready,
  output logic                              busy,
  output logic [MEM_WIDTH-1:0]              credits
);

  localparam int                    LINE_WORDS = 1 << LINE_WIDTH;
  localparam logic [MEM_WIDTH-1:0]  CREDIT_MAX = {MEM_WIDTH{1'b1}};
  localparam logic [MEM_WIDTH-1:0]  CREDIT_ONE = MEM_WIDTH'(1);
  localparam logic [LINE_WIDTH:0]   CNT_ONE    = (LINE_WIDTH+1)'(1);
  localparam logic [LINE_WIDTH:0]   LAST_SLOT  = (LINE_WIDTH+1)'(LINE_WORDS - 1);
  localparam logic [LINE_WIDTH-1:0] PTR_ONE    = LINE_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                 state_q;
  logic [LINE_WIDTH:0]    count_q;
  logic [LINE_WIDTH-1:0]  rd_ptr_q;
  logic [MEM_WIDTH-1:0]   credits_q;
  logic [MEM_WIDTH-1:0]   credits_d;
  logic                   in_ready_q;
  logic                   cache_ready_q;
  logic                   busy_q;
  logic [DATA_WIDTH-1:0]  issue_word_q;
  logic [DATA_WIDTH-1:0]  cache2mem_q;
  logic [DATA_WIDTH-1:0]  line_q [LINE_WORDS];

  logic w_accept;
  logic w_issue;
  logic w_ret;
  logic w_line_end;
  logic w_last_issue;

  // Handshake, issue and end-of-line decodes
  always_comb begin
    w_accept     = in_ready_q & in_valid;
    w_issue      = (state_q == S_DRAIN) && (credits_q != '0);
    w_ret        = |r_ready;
    w_line_end   = in_last || (count_q == LAST_SLOT);
    w_last_issue = w_issue && ({1'b0, rd_ptr_q} == (count_q - CNT_ONE));
  end

  // Credit update; a return that would exceed capacity is dropped
  always_comb begin
    credits_d = credits_q;
    if (w_issue && !w_ret) begin
      credits_d = credits_q - CREDIT_ONE;
    end else if (!w_issue && w_ret && (credits_q != CREDIT_MAX)) begin
      credits_d = credits_q + CREDIT_ONE;
    end
  end

  // Line storage; in IDLE count is zero so the first word lands in slot 0
  always_ff @(posedge clk) begin
    if (w_accept) begin
      line_q[count_q[LINE_WIDTH-1:0]] <= in_data;
    end
  end

  // Fill/drain controller with registered handshake, strobe and data outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      credits_q     <= CREDIT_MAX;
      in_ready_q    <= 1'b0;
      cache_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      issue_word_q  <= '0;
      cache2mem_q   <= '0;
    end else begin
      credits_q     <= credits_d;
      cache_ready_q <= w_issue;
      if (w_issue) begin
        issue_word_q <= line_q[rd_ptr_q];
      end
      // the strobed word reaches the buffer one cycle after its strobe
      if (cache_ready_q) begin
        cache2mem_q <= issue_word_q;
      end
      case (state_q)
        S_IDLE, S_FILL: begin
          if (w_accept) begin
            count_q <= count_q + CNT_ONE;
            busy_q  <= 1'b1;
            if (w_line_end) begin
              state_q    <= S_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q    <= S_FILL;
              in_ready_q <= 1'b1;
            end
          end else begin
            in_ready_q <= 1'b1;
            busy_q     <= (state_q == S_FILL);
          end
        end
        S_DRAIN: begin
          if (w_last_issue) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else if (w_issue) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          count_q    <= '0;
          rd_ptr_q   <= '0;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign cache_ready = cache_ready_q;
  assign cache2mem   = cache2mem_q;
  assign busy        = busy_q;
  assign credits     = credits_q;

`ifndef SYNTHESIS
  // A return arriving with the counter already full means the downstream
  // buffer popped a word this block never sent
  a_credit_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(w_ret && !w_issue && (credits_q == CREDIT_MAX)));
`endif

endmodule
`default_nettype wire
